// File: rtl/dmem_pkg.sv
// Shared types, constants and address check for the data-memory arbiter.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic MEM_RD = 1'b0;
   localparam logic MEM_WR = 1'b1;

   localparam int unsigned DEPTH_BYTES_DEF = 64;

   // Word aligned and fully inside memory; 64-bit compare so addresses near 2^AW cannot wrap.
   function automatic logic word_addr_ok(input logic [63:0] addr, input int unsigned depth);
      return (addr[1:0] == 2'b00) && (depth >= 32'd4) && (addr <= (64'(depth) - 64'd4));
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Grant selection between the two requesters.
// DMEM_ARB_RR_EN defined: ties go to the port named by ptr; otherwise port 0 wins ties.
module dmem_arb_pick (
   input  logic req0,
   input  logic req1,
   input  logic ptr,
   output logic valid,
   output logic id
);

`ifdef DMEM_ARB_RR_EN
   always_comb begin
      valid = req0 | req1;
      if (req0 && req1) begin
         id = ptr;
      end else begin
         id = req1;
      end
   end
`else
   logic ptr_unused;
   assign ptr_unused = ptr;

   always_comb begin
      valid = req0 | req1;
      id    = ~req0 & req1;
   end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the combinational big-endian data memory.
// Build option DMEM_ARB_RR_EN selects round-robin tie-breaking (see dmem_arb_pick).
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH_BYTES = DEPTH_BYTES_DEF,
   parameter int unsigned AW          = 32
) (
   input  logic          CLK,
   input  logic          Reset,
   input  logic          p0_req,
   input  logic          p0_we,
   input  logic [AW-1:0] p0_addr,
   input  logic [31:0]   p0_wdata,
   output logic          p0_done,
   output logic [31:0]   p0_rdata,
   output logic          p0_err,
   input  logic          p1_req,
   input  logic          p1_we,
   input  logic [AW-1:0] p1_addr,
   input  logic [31:0]   p1_wdata,
   output logic          p1_done,
   output logic [31:0]   p1_rdata,
   output logic          p1_err,
   output logic [AW-1:0] mem_addr,
   output logic [31:0]   mem_wdata,
   output logic          mem_rw,
   input  logic [31:0]   mem_rdata,
   output logic          busy
);

   state_t        state, state_nx;
   logic          ptr;
   logic          gid;
   logic          err_l;
   logic          win_valid, win_id, win_we, win_ok;
   logic [AW-1:0] win_addr;
   logic [31:0]   win_wdata;

   dmem_arb_pick u_pick (
      .req0  (p0_req),
      .req1  (p1_req),
      .ptr   (ptr),
      .valid (win_valid),
      .id    (win_id)
   );

   always_comb begin
      win_we    = win_id ? p1_we    : p0_we;
      win_addr  = win_id ? p1_addr  : p0_addr;
      win_wdata = win_id ? p1_wdata : p0_wdata;
      win_ok    = word_addr_ok(64'(win_addr), DEPTH_BYTES);
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (win_valid) state_nx = win_ok ? ACCESS : DONE;
         ACCESS:  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Illegal requests skip ACCESS entirely, so a rejected read clears rdata at grant time.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         ptr       <= 1'b0;
         gid       <= 1'b0;
         err_l     <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rw    <= MEM_RD;
         p0_rdata  <= '0;
         p1_rdata  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (win_valid) begin
                  gid   <= win_id;
                  err_l <= ~win_ok;
                  ptr   <= ~win_id;
                  if (win_ok) begin
                     mem_addr  <= win_addr;
                     mem_wdata <= win_wdata;
                     mem_rw    <= win_we;
                  end else begin
                     mem_rw <= MEM_RD;
                     if (win_we == MEM_RD) begin
                        if (win_id) p1_rdata <= '0;
                        else        p0_rdata <= '0;
                     end
                  end
               end
            end
            ACCESS: begin
               if (mem_rw == MEM_RD) begin
                  if (gid) p1_rdata <= mem_rdata;
                  else     p0_rdata <= mem_rdata;
               end
               mem_rw <= MEM_RD;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy    = (state != IDLE);
      p0_done = (state == DONE) && !gid;
      p1_done = (state == DONE) && gid;
      p0_err  = p0_done && err_l;
      p1_err  = p1_done && err_l;
   end

endmodule
